// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer read-out path.
package la_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    LATCH,
    WAIT
  } dump_state_t;

  localparam logic [7:0] NAK_BYTE = 8'hEE;
  localparam logic [2:0] CH_MIN   = 3'd1;
  localparam logic [2:0] CH_MAX   = 3'd5;

endpackage

// File: rtl/dump_ctrl_wrap_incr.sv
// Modulo-ENTRIES address incrementer; works for non-power-of-2 RAM depths.
module wrap_incr #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic [LOG2-1:0] addr,
  output logic [LOG2-1:0] next
);

  assign next = (addr == LOG2'(ENTRIES - 1)) ? '0 : addr + LOG2'(1);

endmodule

// File: rtl/dump_ctrl.sv
// Sample-RAM dump sequencer: streams one channel's circular buffer, oldest to newest.
//
// state | meaning
// IDLE  | waiting for dump_req; raddr free
// RD    | RAM registers raddr this cycle
// LATCH | capture selected rdata into resp, pulse send_resp
// WAIT  | hold resp/raddr until the transmitter acknowledges
module dump_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_req,
  input  logic [2:0]      dump_ch,
  input  logic [LOG2-1:0] waddr,
  input  logic [7:0]      rdataCH1,
  input  logic [7:0]      rdataCH2,
  input  logic [7:0]      rdataCH3,
  input  logic [7:0]      rdataCH4,
  input  logic [7:0]      rdataCH5,
  input  logic            resp_sent,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      resp,
  output logic            send_resp,
  output logic            busy,
  output logic            dump_done
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  dump_state_t     state;
  logic [2:0]      ch_q;
  logic [LOG2-1:0] cnt;
  logic [LOG2-1:0] raddr_next;
  logic [7:0]      rdata_sel;

  wrap_incr #(.ENTRIES(ENTRIES), .LOG2(LOG2)) u_wrap_incr (
    .addr (raddr),
    .next (raddr_next)
  );

  always_comb begin
    rdata_sel = '0;
    case (ch_q)
      3'd1:    rdata_sel = rdataCH1;
      3'd2:    rdata_sel = rdataCH2;
      3'd3:    rdata_sel = rdataCH3;
      3'd4:    rdata_sel = rdataCH4;
      3'd5:    rdata_sel = rdataCH5;
      default: rdata_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch_q      <= '0;
      cnt       <= '0;
      raddr     <= '0;
      resp      <= '0;
      send_resp <= 1'b0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      send_resp <= 1'b0;
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            busy <= 1'b1;
            if (dump_ch >= CH_MIN && dump_ch <= CH_MAX) begin
              ch_q  <= dump_ch;
              raddr <= waddr;
              cnt   <= '0;
              state <= RD;
            end else begin
              // NAK is a one-byte dump: cnt starts at the end so the ack finishes it
              resp      <= NAK_BYTE;
              send_resp <= 1'b1;
              cnt       <= LAST;
              state     <= WAIT;
            end
          end
        end
        RD: state <= LATCH;
        LATCH: begin
          resp      <= rdata_sel;
          send_resp <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          // An ack coincident with our own start pulse cannot belong to this byte
          if (resp_sent && !send_resp) begin
            if (cnt == LAST) begin
              dump_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt   <= cnt + LOG2'(1);
              raddr <= raddr_next;
              state <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_ctrl.sv
// Scoreboard bench for dump_ctrl: RAM models, ack responder, per-scenario tasks.
module tb_dump_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk;
  logic            rst_n;
  logic            dump_req;
  logic [2:0]      dump_ch;
  logic [LOG2-1:0] waddr;
  logic [7:0]      rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5;
  logic            resp_sent;
  logic [LOG2-1:0] raddr;
  logic [7:0]      resp;
  logic            send_resp;
  logic            busy;
  logic            dump_done;

  dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dump_req  (dump_req),
    .dump_ch   (dump_ch),
    .waddr     (waddr),
    .rdataCH1  (rdataCH1),
    .rdataCH2  (rdataCH2),
    .rdataCH3  (rdataCH3),
    .rdataCH4  (rdataCH4),
    .rdataCH5  (rdataCH5),
    .resp_sent (resp_sent),
    .raddr     (raddr),
    .resp      (resp),
    .send_resp (send_resp),
    .busy      (busy),
    .dump_done (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   done_cnt   = 0;
  int   bytes_seen = 0;
  int   last_send  = -1;
  int   last_addr  = 0;
  bit   prev_send  = 1'b0;
  bit   ack_hold   = 1'b0;
  int   ack_delay  = 5;
  int   pend       = 0;

  function automatic logic [7:0] ram_val(input int c, input int a);
    int v;
    v = (c == 3) ? a : a * c + 17 * c;
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdataCH1 <= ram_val(1, int'(raddr));
    rdataCH2 <= ram_val(2, int'(raddr));
    rdataCH3 <= ram_val(3, int'(raddr));
    rdataCH4 <= ram_val(4, int'(raddr));
    rdataCH5 <= ram_val(5, int'(raddr));
  end

  // transmitter model: ack ack_delay cycles after each send_resp, or hold ack high
  initial begin
    resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        resp_sent = 1'b0;
      end else if (ack_hold) begin
        pend = 0;
        resp_sent = 1'b1;
      end else begin
        resp_sent = 1'b0;
        if (send_resp) pend = ack_delay;
        else if (pend > 0) begin
          pend--;
          if (pend == 0) resp_sent = 1'b1;
        end
      end
    end
  end

  // scoreboard consumer
  always @(negedge clk) begin
    if (rst_n) begin
      if (send_resp) begin
        checks++;
        if (prev_send) begin
          errors++;
          $display("FAIL send_back_to_back: send_resp high two cycles at cyc %0d", cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_send: resp=%02h raddr=%0d with no byte expected", resp, raddr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (resp !== e.data) begin
            errors++;
            $display("FAIL byte_data: got %02h expected %02h (addr %0d)", resp, e.data, e.addr);
          end
          checks++;
          if (int'(raddr) !== e.addr) begin
            errors++;
            $display("FAIL byte_addr: raddr %0d expected %0d", raddr, e.addr);
          end
        end
        if (ack_hold && last_send >= 0) begin
          checks++;
          if (cyc - last_send != 4) begin
            errors++;
            $display("FAIL byte_interval: got %0d cycles expected 4", cyc - last_send);
          end
        end
        last_send = cyc;
        bytes_seen++;
      end
      if (busy && raddr >= LOG2'(ENTRIES)) begin
        checks++;
        errors++;
        $display("FAIL raddr_range: raddr %0d expected < %0d", raddr, ENTRIES);
      end
      if (dump_done) begin
        done_cnt++;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL done_busy: busy %b expected 0 with dump_done", busy);
        end
      end
      prev_send = send_resp;
    end else begin
      prev_send = 1'b0;
    end
  end

  // caller is between edges; request is sampled at the next posedge
  task automatic start_dump(input logic [2:0] ch, input int wa, input bit valid);
    dump_ch  = ch;
    waddr    = LOG2'(wa);
    dump_req = 1'b1;
    last_send = -1;
    if (valid) begin
      for (int j = 0; j < ENTRIES; j++) begin
        int a;
        a = (wa + j) % ENTRIES;
        exp_q.push_back('{data: ram_val(int'(ch), a), addr: a});
      end
    end else begin
      exp_q.push_back('{data: 8'hEE, addr: last_addr});
    end
    @(negedge clk);
    #1;
    dump_req = 1'b0;
    if (valid) last_addr = (wa + ENTRIES - 1) % ENTRIES;
  endtask

  task automatic wait_done(input string name, input int budget);
    int target;
    target = done_cnt + 1;
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: dump_done count %0d expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d bytes outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks += 5;
    if (raddr !== '0)      begin errors++; $display("FAIL reset_raddr: got %0d expected 0", raddr); end
    if (resp !== 8'h00)    begin errors++; $display("FAIL reset_resp: got %02h expected 00", resp); end
    if (send_resp !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", send_resp); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", dump_done); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_basic;
    int b0, d0;
    ack_delay = 5;
    b0 = bytes_seen;
    d0 = done_cnt;
    start_dump(3'd3, 100, 1'b1);
    checks += 2;
    if (raddr !== LOG2'(100)) begin errors++; $display("FAIL basic_start_raddr: got %0d expected 100", raddr); end
    if (busy !== 1'b1)        begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_done("basic", 8000);
    repeat (5) @(negedge clk);
    #1;
    check_drained("basic");
    checks += 2;
    if (bytes_seen - b0 != ENTRIES) begin errors++; $display("FAIL basic_count: got %0d bytes expected %0d", bytes_seen - b0, ENTRIES); end
    if (done_cnt - d0 != 1)         begin errors++; $display("FAIL basic_done_once: got %0d pulses expected 1", done_cnt - d0); end
  endtask

  task automatic test_wrap;
    ack_delay = 1;
    start_dump(3'd5, 383, 1'b1);
    checks++;
    if (raddr !== LOG2'(383)) begin errors++; $display("FAIL wrap_start_raddr: got %0d expected 383", raddr); end
    wait_done("wrap", 6000);
    check_drained("wrap");
  endtask

  task automatic test_invalid;
    int b0;
    ack_delay = 3;
    b0 = bytes_seen;
    start_dump(3'd0, 5, 1'b0);
    wait_done("nak_ch0", 100);
    start_dump(3'd6, 9, 1'b0);
    wait_done("nak_ch6", 100);
    check_drained("invalid");
    checks += 2;
    if (bytes_seen - b0 != 2) begin errors++; $display("FAIL nak_count: got %0d sends expected 2", bytes_seen - b0); end
    if (int'(raddr) !== last_addr) begin errors++; $display("FAIL nak_raddr: got %0d expected %0d", raddr, last_addr); end
  endtask

  task automatic test_timing;
    ack_hold = 1'b1;
    @(negedge clk);
    #1;
    start_dump(3'd1, 7, 1'b1);
    checks += 3;
    if (busy !== 1'b1)       begin errors++; $display("FAIL t_busy_k: got %b expected 1", busy); end
    if (raddr !== LOG2'(7))  begin errors++; $display("FAIL t_raddr_k: got %0d expected 7", raddr); end
    if (send_resp !== 1'b0)  begin errors++; $display("FAIL t_send_k: got %b expected 0", send_resp); end
    @(negedge clk);
    #1;
    checks++;
    if (send_resp !== 1'b0)  begin errors++; $display("FAIL t_send_k1: got %b expected 0", send_resp); end
    @(negedge clk);
    #1;
    checks++;
    if (send_resp !== 1'b1)  begin errors++; $display("FAIL t_send_k2: got %b expected 1", send_resp); end
    repeat (10) @(negedge clk);
    #1;
    dump_req = 1'b1;
    dump_ch  = 3'd2;
    waddr    = '0;
    @(negedge clk);
    #1;
    dump_req = 1'b0;
    wait_done("timing", 3000);
    start_dump(3'd7, 0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t_req_m1: busy %b expected 1", busy); end
    wait_done("timing_nak", 100);
    check_drained("timing");
    ack_hold = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int b0, d0;
    ack_delay = 2;
    b0 = bytes_seen;
    start_dump(3'd2, 200, 1'b1);
    for (int i = 0; i < 2000 && bytes_seen - b0 < 50; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (bytes_seen - b0 < 50) begin errors++; $display("FAIL rstmid_progress: got %0d bytes expected 50", bytes_seen - b0); end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (raddr !== '0)       begin errors++; $display("FAIL rstmid_raddr: got %0d expected 0", raddr); end
    if (resp !== 8'h00)     begin errors++; $display("FAIL rstmid_resp: got %02h expected 00", resp); end
    if (send_resp !== 1'b0) begin errors++; $display("FAIL rstmid_send: got %b expected 0", send_resp); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (dump_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", dump_done); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt - d0); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    waddr = LOG2'(10);
    start_dump(3'd4, 10, 1'b1);
    checks++;
    if (raddr !== LOG2'(10)) begin errors++; $display("FAIL rstmid_restart: raddr %0d expected 10", raddr); end
    wait_done("rstmid_restart", 5000);
    check_drained("rstmid");
  endtask

  task automatic test_waddr_toggle;
    int target;
    ack_delay = 1;
    target = done_cnt + 1;
    start_dump(3'd1, 50, 1'b1);
    for (int i = 0; i < 6000 && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
      waddr = LOG2'($urandom_range(0, ENTRIES - 1));
    end
    checks++;
    if (done_cnt < target) begin errors++; $display("FAIL toggle_timeout: done %0d expected %0d", done_cnt, target); end
    check_drained("toggle");
  endtask

  initial begin
    rst_n    = 1'b0;
    dump_req = 1'b0;
    dump_ch  = 3'd0;
    waddr    = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_invalid();
    test_timing();
    test_reset_mid();
    test_waddr_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
